// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch port and the load/store port. One requester is granted at
// a time; the memory request is held until mem_ack (or a timeout abort), then
// a one-cycle ready pulse and registered read data go back to the winner.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 3,
   parameter int TIMEOUT      = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_rd,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic              err
);

   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IF_ACC = 2'd1,
      ST_DM_ACC = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [SW-1:0]   r_starve_cnt;
   logic [SW-1:0]   w_starve_nxt;
   logic [TW-1:0]   r_tmo_cnt;
   logic [TW-1:0]   w_tmo_nxt;
   logic            w_err_nxt;
   logic            w_mem_en_nxt;
   logic            w_mem_we_nxt;
   logic [ADDR_W-1:0] w_mem_addr_nxt;
   logic [DATA_W-1:0] w_mem_wdata_nxt;
   logic [DATA_W-1:0] w_if_rdata_nxt;
   logic [DATA_W-1:0] w_dm_rdata_nxt;
   logic            w_if_ready_nxt;
   logic            w_dm_ready_nxt;
   logic            w_dm_req;

   assign w_dm_req = dm_rd | dm_wr;

   // Stall the pipeline while any request is outstanding and not yet answered.
   assign stall = (if_req & ~if_ready) | (w_dm_req & ~dm_ready);

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      w_state_nxt     = r_state;
      w_starve_nxt    = r_starve_cnt;
      w_tmo_nxt       = r_tmo_cnt;
      w_err_nxt       = err;
      w_mem_en_nxt    = mem_en;
      w_mem_we_nxt    = mem_we;
      w_mem_addr_nxt  = mem_addr;
      w_mem_wdata_nxt = mem_wdata;
      w_if_rdata_nxt  = if_rdata;
      w_dm_rdata_nxt  = dm_rdata;
      w_if_ready_nxt  = 1'b0;
      w_dm_ready_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // Data port wins unless fetch has already waited STARVE_LIMIT grants.
            if (w_dm_req && (!if_req || (r_starve_cnt < SW'(STARVE_LIMIT)))) begin
               w_state_nxt     = ST_DM_ACC;
               w_mem_en_nxt    = 1'b1;
               w_mem_we_nxt    = dm_wr;
               w_mem_addr_nxt  = dm_addr;
               w_mem_wdata_nxt = dm_wdata;
               w_tmo_nxt       = '0;
               if (if_req) begin
                  if (r_starve_cnt != SW'(STARVE_LIMIT))
                     w_starve_nxt = r_starve_cnt + 1'b1;
               end else begin
                  w_starve_nxt = '0;
               end
            end else if (if_req) begin
               w_state_nxt     = ST_IF_ACC;
               w_mem_en_nxt    = 1'b1;
               w_mem_we_nxt    = 1'b0;
               w_mem_addr_nxt  = if_addr;
               w_mem_wdata_nxt = '0;
               w_tmo_nxt       = '0;
               w_starve_nxt    = '0;
            end
         end

         ST_IF_ACC, ST_DM_ACC: begin
            if (mem_ack || (r_tmo_cnt == TW'(TIMEOUT - 1))) begin
               // Completion or abort: release memory and answer the requester.
               // An aborted read returns zero and latches the error flag.
               w_state_nxt  = ST_RESP;
               w_mem_en_nxt = 1'b0;
               w_mem_we_nxt = 1'b0;
               if (!mem_ack)
                  w_err_nxt = 1'b1;
               if (r_state == ST_IF_ACC) begin
                  w_if_ready_nxt = 1'b1;
                  w_if_rdata_nxt = mem_ack ? mem_rdata : '0;
               end else begin
                  w_dm_ready_nxt = 1'b1;
                  if (!mem_we)
                     w_dm_rdata_nxt = mem_ack ? mem_rdata : '0;
               end
            end else begin
               w_tmo_nxt = r_tmo_cnt + 1'b1;
            end
         end

         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counters and all registered outputs; reset aborts any access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= '0;
         r_tmo_cnt    <= '0;
         err          <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         if_rdata     <= '0;
         dm_rdata     <= '0;
         if_ready     <= 1'b0;
         dm_ready     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_tmo_cnt    <= w_tmo_nxt;
         err          <= w_err_nxt;
         mem_en       <= w_mem_en_nxt;
         mem_we       <= w_mem_we_nxt;
         mem_addr     <= w_mem_addr_nxt;
         mem_wdata    <= w_mem_wdata_nxt;
         if_rdata     <= w_if_rdata_nxt;
         dm_rdata     <= w_dm_rdata_nxt;
         if_ready     <= w_if_ready_nxt;
         dm_ready     <= w_dm_ready_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays the memory by driving
// mem_ack/mem_rdata cycle by cycle and checks outputs 1 time unit after each edge.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_rd;
   logic        dm_wr;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        err;

   int n_vec;
   int n_err;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3), .TIMEOUT(15)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({mem_en, mem_we, if_ready, dm_ready, err} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b required 00000", {mem_en, mem_we, if_ready, dm_ready, err});
      end
      n_vec++;
      if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
         n_err++;
         $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
      end
      n_vec++;
      if (dm_rdata !== 32'h0 || dut.r_state !== 2'd0 || dut.r_starve_cnt !== 2'd0 || dut.r_tmo_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL reset_state: state %0d starve %0d tmo %0d required 0/0/0",
                  dut.r_state, dut.r_starve_cnt, dut.r_tmo_cnt);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      if_req  = 1'b1;
      if_addr = 32'h10;
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
         n_err++;
         $display("FAIL fetch_stall_wait: got %b required 1", stall);
      end
      tick();
      n_vec++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || mem_wdata !== 32'h0) begin
         n_err++;
         $display("FAIL fetch_grant: en %b we %b addr %h wdata %h required 1 0 10 0",
                  mem_en, mem_we, mem_addr, mem_wdata);
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h00500093;
      tick();
      n_vec++;
      if (if_ready !== 1'b1 || if_rdata !== 32'h00500093 || stall !== 1'b0 || mem_en !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_done: ready %b rdata %h stall %b en %b required 1 00500093 0 0",
                  if_ready, if_rdata, stall, mem_en);
      end
      mem_ack = 1'b0;
      if_req  = 1'b0;
      tick();
      n_vec++;
      if (if_ready !== 1'b0 || if_rdata !== 32'h00500093) begin
         n_err++;
         $display("FAIL fetch_pulse_end: ready %b rdata %h required 0 00500093", if_ready, if_rdata);
      end
   endtask

   task automatic test_simultaneous();
      if_req  = 1'b1;
      if_addr = 32'h20;
      dm_rd   = 1'b1;
      dm_addr = 32'h40;
      tick();
      n_vec++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || dut.r_starve_cnt !== 2'd1) begin
         n_err++;
         $display("FAIL sim_dm_first: en %b addr %h we %b starve %0d required 1 40 0 1",
                  mem_en, mem_addr, mem_we, dut.r_starve_cnt);
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h11112222;
      tick();
      n_vec++;
      if (dm_ready !== 1'b1 || if_ready !== 1'b0 || dm_rdata !== 32'h11112222) begin
         n_err++;
         $display("FAIL sim_dm_done: dm_ready %b if_ready %b dm_rdata %h required 1 0 11112222",
                  dm_ready, if_ready, dm_rdata);
      end
      mem_ack = 1'b0;
      dm_rd   = 1'b0;
      tick();
      tick();
      n_vec++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h20 || dut.r_starve_cnt !== 2'd0) begin
         n_err++;
         $display("FAIL sim_if_second: en %b addr %h starve %0d required 1 20 0",
                  mem_en, mem_addr, dut.r_starve_cnt);
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'hAAAA5555;
      tick();
      n_vec++;
      if (if_ready !== 1'b1 || if_rdata !== 32'hAAAA5555 || dm_rdata !== 32'h11112222) begin
         n_err++;
         $display("FAIL sim_if_done: ready %b if_rdata %h dm_rdata %h required 1 aaaa5555 11112222",
                  if_ready, if_rdata, dm_rdata);
      end
      mem_ack = 1'b0;
      if_req  = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      logic [31:0] exp_addr;
      if_req  = 1'b1;
      if_addr = 32'h30;
      dm_rd   = 1'b1;
      dm_addr = 32'h80;
      for (int g = 0; g < 4; g++) begin
         exp_addr = (g < 3) ? 32'h80 : 32'h30;
         tick();
         n_vec++;
         if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin
            n_err++;
            $display("FAIL starve_grant%0d: en %b addr %h required 1 %h", g, mem_en, mem_addr, exp_addr);
         end
         mem_ack   = 1'b1;
         mem_rdata = 32'h10000000 + 32'(g);
         tick();
         n_vec++;
         if (dm_ready !== (g < 3) || if_ready !== (g == 3)) begin
            n_err++;
            $display("FAIL starve_ready%0d: dm %b if %b required %b %b", g, dm_ready, if_ready,
                     (g < 3), (g == 3));
         end
         mem_ack = 1'b0;
         tick();
      end
      if_req = 1'b0;
      dm_rd  = 1'b0;
      n_vec++;
      if (dm_rdata !== 32'h10000002 || if_rdata !== 32'h10000003 || dut.r_starve_cnt !== 2'd0) begin
         n_err++;
         $display("FAIL starve_final: dm %h if %h starve %0d required 10000002 10000003 0",
                  dm_rdata, if_rdata, dut.r_starve_cnt);
      end
   endtask

   task automatic test_store();
      dm_rd    = 1'b1;
      dm_wr    = 1'b1;
      dm_addr  = 32'h8;
      dm_wdata = 32'hDEADBEEF;
      tick();
      n_vec++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL store_grant: en %b we %b addr %h wdata %h required 1 1 8 deadbeef",
                  mem_en, mem_we, mem_addr, mem_wdata);
      end
      mem_ack   = 1'b1;
      mem_rdata = 32'h55555555;
      tick();
      n_vec++;
      if (dm_ready !== 1'b1 || dm_rdata !== 32'h10000002 || mem_we !== 1'b0) begin
         n_err++;
         $display("FAIL store_done: ready %b rdata %h we %b required 1 10000002 0",
                  dm_ready, dm_rdata, mem_we);
      end
      mem_ack = 1'b0;
      dm_rd   = 1'b0;
      dm_wr   = 1'b0;
      tick();
      n_vec++;
      if (dm_ready !== 1'b0 || dm_rdata !== 32'h10000002) begin
         n_err++;
         $display("FAIL store_pulse_end: ready %b rdata %h required 0 10000002", dm_ready, dm_rdata);
      end
   endtask

   task automatic test_timeout();
      int early;
      if_req  = 1'b1;
      if_addr = 32'h44;
      mem_ack = 1'b0;
      tick();
      early = 0;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (if_ready !== 1'b0 || err !== 1'b0 || mem_en !== 1'b1) early++;
      end
      n_vec++;
      if (early != 0) begin
         n_err++;
         $display("FAIL timeout_early: %0d bad cycles required 0", early);
      end
      tick();
      n_vec++;
      if (if_ready !== 1'b1 || if_rdata !== 32'h0 || err !== 1'b1 || mem_en !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_abort: ready %b rdata %h err %b en %b required 1 0 1 0",
                  if_ready, if_rdata, err, mem_en);
      end
      if_req = 1'b0;
      tick();
      tick();
      tick();
      n_vec++;
      if (err !== 1'b1 || if_ready !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_sticky: err %b ready %b required 1 0", err, if_ready);
      end
   endtask

   task automatic test_reset_mid_access();
      dm_rd   = 1'b1;
      dm_addr = 32'h60;
      tick();
      n_vec++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h60) begin
         n_err++;
         $display("FAIL rst_mid_grant: en %b addr %h required 1 60", mem_en, mem_addr);
      end
      reset = 1'b0;
      tick();
      n_vec++;
      if (mem_en !== 1'b0 || dm_ready !== 1'b0 || err !== 1'b0 || dut.r_state !== 2'd0) begin
         n_err++;
         $display("FAIL rst_mid_abort: en %b ready %b err %b state %0d required 0 0 0 0",
                  mem_en, dm_ready, err, dut.r_state);
      end
      reset     = 1'b1;
      dm_rd     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h99999999;
      tick();
      n_vec++;
      if (mem_en !== 1'b0 || dm_ready !== 1'b0 || dm_rdata !== 32'h0 || dut.r_state !== 2'd0) begin
         n_err++;
         $display("FAIL rst_late_ack: en %b ready %b rdata %h state %0d required 0 0 0 0",
                  mem_en, dm_ready, dm_rdata, dut.r_state);
      end
      mem_ack = 1'b0;
      tick();
      n_vec++;
      if (dm_ready !== 1'b0 || if_ready !== 1'b0 || stall !== 1'b0) begin
         n_err++;
         $display("FAIL rst_quiet: dm %b if %b stall %b required 0 0 0", dm_ready, if_ready, stall);
      end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b0;
      if_req    = 1'b0;
      if_addr   = '0;
      dm_rd     = 1'b0;
      dm_wr     = 1'b0;
      dm_addr   = '0;
      dm_wdata  = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      test_reset();
      test_fetch();
      test_simultaneous();
      test_starvation();
      test_store();
      test_timeout();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw, driven by the decoder's MemRead/MemWrite).
- Grants one requester at a time and holds the memory request until acknowledge.
- Returns read data and a one-cycle ready pulse to the served requester, and drives the pipeline stall.
- Sits between the pipeline stage registers and the memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 3, consecutive DM grants allowed while IF waits before IF is forced.
- TIMEOUT, 15, maximum cycles in an access state without mem_ack before abort.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  registered fetched instruction.
- if_ready  out  1  one-cycle pulse, fetch complete.
- dm_rd  in  1  data read request (MemRead).
- dm_wr  in  1  data write request (MemWrite).
- dm_addr  in  ADDR_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  registered load data.
- dm_ready  out  1  one-cycle pulse, data access complete.
- mem_en  out  1  memory request valid.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  access complete.
- stall  out  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).
- err  out  1  sticky timeout flag.

Behaviour:
- dm_req = dm_rd | dm_wr. If both are high, the access is a write: mem_we=1 and dm_rdata is not updated.
- Reset (reset==0 at an edge):
  - state=IDLE, starve_cnt=0, tmo_cnt=0, err=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0.
  - Reset mid-access aborts: no ready pulse is issued, and a late mem_ack is ignored.
- States: IDLE, IF_ACC, DM_ACC, RESP. All mem_* and ready outputs are registered.
- IDLE arbitration:
  - dm_req & (~if_req | starve_cnt<STARVE_LIMIT) -> DM_ACC.
    - starve_cnt increments if if_req is high, otherwise clears to 0.
  - Else if_req -> IF_ACC, starve_cnt=0.
  - Else stay in IDLE.
  - On the entering edge: mem_en=1, mem_addr, mem_we and mem_wdata are latched from the winner. mem_wdata=0 for fetch. tmo_cnt=0.
- IF_ACC/DM_ACC:
  - mem_* are held stable. Requester inputs are not re-sampled, so changes during the access are ignored.
  - mem_ack=1 -> RESP; mem_en=0, mem_we=0.
    - Load or fetch: mem_rdata captured into dm_rdata or if_rdata.
    - Ready of the served requester set to 1.
  - mem_ack=0: tmo_cnt++. When tmo_cnt==TIMEOUT-1 with no ack -> RESP.
    - Ready pulses; rdata is loaded with 0; err=1 (cleared only by reset).
- RESP: ready high for exactly this cycle, then IDLE unconditionally. The requester must drop or advance its request by the following cycle.
- Latency: with mem_ack on the first access cycle, ready is asserted 2 cycles after the request is sampled. Minimum spacing between grants is 3 cycles.
- mem_ack while in IDLE or RESP is ignored.
- rdata registers hold their value until the next completed read of the same port.
- No counter wraps: starve_cnt saturates at STARVE_LIMIT, and tmo_cnt is bounded by TIMEOUT.

Test Plan:
- Fetch only: if_req=1, if_addr=0x10, memory acks on the first cycle with 0x00500093 -> if_ready pulses 1 cycle at T+2, if_rdata=0x00500093, stall=0 in the pulse cycle.
- Simultaneous requests with starve_cnt=0: if_req=1, dm_rd=1, dm_addr=0x40 -> DM served first (mem_addr=0x40, mem_we=0), then IF. starve_cnt returns to 0 after the IF grant.
- Starvation: dm_rd held continuously with if_req=1, ack latency 1 -> exactly 3 DM grants, the 4th grant goes to IF (mem_addr=if_addr).
- Store with dm_rd=dm_wr=1: dm_addr=0x8, dm_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF. dm_rdata is unchanged and dm_ready pulses once.
- Timeout: grant IF with mem_ack never asserted -> if_ready pulses after 15 access cycles, if_rdata=0, err=1 and stays 1 until reset.
- Reset mid-access: reset=0 during DM_ACC, then mem_ack=1 after release -> mem_en=0, no dm_ready pulse, state IDLE.
